// File: rtl/spi_master_mc_if.sv
// Command/response/config/SPI-pin bundle for spi_master_mc.
// The master modport is the SPI master itself; slave is the requesting side.
interface spi_master_mc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SS_COUNT   = 4,
  parameter int DIV_WIDTH  = 16
);
  localparam int SS_W = (SS_COUNT > 1) ? $clog2(SS_COUNT) : 1;

  logic                  io_cmd_valid;
  logic                  io_cmd_ready;
  logic [DATA_WIDTH-1:0] io_cmd_data;
  logic [SS_W-1:0]       io_cmd_ss;
  logic                  io_cmd_keepSs;
  logic                  io_rsp_valid;
  logic [DATA_WIDTH-1:0] io_rsp_data;
  logic                  io_cfg_cpol;
  logic                  io_cfg_cpha;
  logic                  io_cfg_lsbFirst;
  logic [DIV_WIDTH-1:0]  io_cfg_divider;
  logic                  io_busy;
  logic                  io_spi_sclk;
  logic                  io_spi_mosi;
  logic                  io_spi_miso;
  logic [SS_COUNT-1:0]   io_spi_ss;

  modport master (
    input  io_cmd_valid, io_cmd_data, io_cmd_ss, io_cmd_keepSs,
           io_cfg_cpol, io_cfg_cpha, io_cfg_lsbFirst, io_cfg_divider, io_spi_miso,
    output io_cmd_ready, io_rsp_valid, io_rsp_data, io_busy,
           io_spi_sclk, io_spi_mosi, io_spi_ss
  );

  modport slave (
    output io_cmd_valid, io_cmd_data, io_cmd_ss, io_cmd_keepSs,
           io_cfg_cpol, io_cfg_cpha, io_cfg_lsbFirst, io_cfg_divider, io_spi_miso,
    input  io_cmd_ready, io_rsp_valid, io_rsp_data, io_busy,
           io_spi_sclk, io_spi_mosi, io_spi_ss
  );
endinterface

// File: rtl/spi_master_mc.sv
// Multi-slave SPI master: one word per command, all four SPI modes, either bit order,
// optional slave-select hold across words with automatic deselect when the target changes.
module spi_master_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int SS_COUNT   = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic            io_clock,
  input  logic            io_reset_n,
  spi_master_mc_if.master bus
);
  localparam int SS_W  = (SS_COUNT > 1) ? $clog2(SS_COUNT) : 1;
  localparam int CNT_W = $clog2(2 * DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DESELECT} state_t;

  state_t                state_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DIV_WIDTH-1:0]  div_cnt_q;
  logic [CNT_W-1:0]      edge_cnt_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [SS_W-1:0]       ss_idx_q;
  logic [SS_COUNT-1:0]   ss_q;
  logic                  cpha_q, lsb_q, keep_q, held_q, pend_q;
  logic                  sclk_q, mosi_q, rsp_valid_q, busy_q, ready_q;

  logic                  hp_done, accept, shift_tick;
  logic                  leading, last_edge, sample_now, drive_now;
  logic [DATA_WIDTH-1:0] tx_d, rx_d;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                      input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Out-of-range indices decode to no active select.
  function automatic logic [SS_COUNT-1:0] ss_decode(input logic [SS_W-1:0] idx);
    logic [SS_COUNT-1:0] v;
    v = '1;
    for (int i = 0; i < SS_COUNT; i++) begin
      if (idx == SS_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  assign hp_done    = (div_cnt_q == div_q);
  assign accept     = (state_q == IDLE) && ready_q && bus.io_cmd_valid;
  assign shift_tick = (state_q == SHIFT) && hp_done;
  assign leading    = ~edge_cnt_q[0];
  assign last_edge  = (edge_cnt_q == CNT_W'(2 * DATA_WIDTH - 1));
  assign sample_now = cpha_q ? ~leading : leading;
  // With cpha=0 the first bit is launched at accept, so the final trailing edge has nothing left to drive.
  assign drive_now  = cpha_q ? leading : (~leading && !last_edge);
  assign tx_d       = shift_out(tx_q, lsb_q);
  assign rx_d       = lsb_q ? {bus.io_spi_miso, rx_q[DATA_WIDTH-1:1]}
                            : {rx_q[DATA_WIDTH-2:0], bus.io_spi_miso};

  always_ff @(posedge io_clock) begin
    if (accept) begin
      tx_q <= bus.io_cfg_cpha ? bus.io_cmd_data : shift_out(bus.io_cmd_data, bus.io_cfg_lsbFirst);
      rx_q <= '0;
    end else if (shift_tick) begin
      if (drive_now)  tx_q <= tx_d;
      if (sample_now) rx_q <= rx_d;
    end
  end

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      div_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      ss_idx_q    <= '0;
      ss_q        <= '1;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      keep_q      <= 1'b0;
      held_q      <= 1'b0;
      pend_q      <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      div_cnt_q   <= (state_q == IDLE || hp_done) ? '0 : div_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            div_q      <= bus.io_cfg_divider;
            cpha_q     <= bus.io_cfg_cpha;
            lsb_q      <= bus.io_cfg_lsbFirst;
            ss_idx_q   <= bus.io_cmd_ss;
            keep_q     <= bus.io_cmd_keepSs;
            edge_cnt_q <= '0;
            sclk_q     <= bus.io_cfg_cpol;
            if (!bus.io_cfg_cpha) mosi_q <= first_bit(bus.io_cmd_data, bus.io_cfg_lsbFirst);
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            held_q     <= 1'b0;
            // A held select for a different slave must be released before the new one falls.
            if (held_q && (bus.io_cmd_ss != ss_idx_q)) begin
              ss_q    <= '1;
              pend_q  <= 1'b1;
              state_q <= DESELECT;
            end else begin
              ss_q    <= ss_decode(bus.io_cmd_ss);
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          if (hp_done) state_q <= SHIFT;
        end
        SHIFT: begin
          if (hp_done) begin
            sclk_q     <= ~sclk_q;
            edge_cnt_q <= edge_cnt_q + 1'b1;
            if (drive_now) mosi_q <= first_bit(tx_q, lsb_q);
            if (last_edge) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (hp_done) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rx_q;
            if (keep_q) begin
              held_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ss_q    <= '1;
              state_q <= DESELECT;
            end
          end
        end
        DESELECT: begin
          if (hp_done) begin
            if (pend_q) begin
              pend_q  <= 1'b0;
              ss_q    <= ss_decode(ss_idx_q);
              state_q <= SETUP;
            end else begin
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.io_cmd_ready = ready_q;
  assign bus.io_rsp_valid = rsp_valid_q;
  assign bus.io_rsp_data  = rsp_data_q;
  assign bus.io_busy      = busy_q;
  assign bus.io_spi_sclk  = sclk_q;
  assign bus.io_spi_mosi  = mosi_q;
  assign bus.io_spi_ss    = ss_q;
endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: default 8-bit/4-slave instance plus a 32-bit/1-slave instance.
module tb_spi_master_mc;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  spi_master_mc_if #(.DATA_WIDTH(8),  .SS_COUNT(4), .DIV_WIDTH(16)) if0 ();
  spi_master_mc_if #(.DATA_WIDTH(32), .SS_COUNT(1), .DIV_WIDTH(16)) if1 ();

  spi_master_mc #(.DATA_WIDTH(8), .SS_COUNT(4), .DIV_WIDTH(16)) dut0 (
    .io_clock(clk), .io_reset_n(rst_n), .bus(if0)
  );
  spi_master_mc #(.DATA_WIDTH(32), .SS_COUNT(1), .DIV_WIDTH(16)) dut1 (
    .io_clock(clk), .io_reset_n(rst_n), .bus(if1)
  );

  logic loop0 = 1'b1, tie0 = 1'b0, loop1 = 1'b1;
  assign if0.io_spi_miso = loop0 ? if0.io_spi_mosi : tie0;
  assign if1.io_spi_miso = loop1 ? if1.io_spi_mosi : 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observers for dut0
  int tog0, gap0, gmin0, gmax0, rsp_n0, ss_multi0, ss1_rise0;
  logic [7:0] mseq0, rsp_last0;
  logic [3:0] ss_seen0;
  logic prev_sclk0 = 1'b0, prev_busy0 = 1'b0, prev_ss1_0 = 1'b1;

  always @(negedge clk) begin
    gap0 = gap0 + 1;
    if (prev_busy0 && if0.io_busy && (if0.io_spi_sclk != prev_sclk0)) begin
      if (tog0 > 0) begin
        if (gap0 < gmin0) gmin0 = gap0;
        if (gap0 > gmax0) gmax0 = gap0;
      end
      tog0 = tog0 + 1;
      gap0 = 0;
      if (if0.io_spi_sclk) mseq0 = {mseq0[6:0], if0.io_spi_mosi};
    end
    if ($countones(~if0.io_spi_ss) > 1) ss_multi0 = ss_multi0 + 1;
    ss_seen0 = ss_seen0 | ~if0.io_spi_ss;
    if (!prev_ss1_0 && if0.io_spi_ss[1]) ss1_rise0 = ss1_rise0 + 1;
    if (if0.io_rsp_valid) begin
      rsp_n0    = rsp_n0 + 1;
      rsp_last0 = if0.io_rsp_data;
    end
    prev_sclk0 = if0.io_spi_sclk;
    prev_busy0 = if0.io_busy;
    prev_ss1_0 = if0.io_spi_ss[1];
  end

  // Observers for dut1
  int tog1, gap1, gmin1, gmax1, rsp_n1, ss_low1;
  logic prev_sclk1 = 1'b0, prev_busy1 = 1'b0;

  always @(negedge clk) begin
    gap1 = gap1 + 1;
    if (prev_busy1 && if1.io_busy && (if1.io_spi_sclk != prev_sclk1)) begin
      if (tog1 > 0) begin
        if (gap1 < gmin1) gmin1 = gap1;
        if (gap1 > gmax1) gmax1 = gap1;
      end
      tog1 = tog1 + 1;
      gap1 = 0;
    end
    if (if1.io_spi_ss == 1'b0) ss_low1 = ss_low1 + 1;
    if (if1.io_rsp_valid) rsp_n1 = rsp_n1 + 1;
    prev_sclk1 = if1.io_spi_sclk;
    prev_busy1 = if1.io_busy;
  end

  task automatic clr0();
    tog0 = 0; gap0 = 0; gmin0 = 9999; gmax0 = 0; rsp_n0 = 0;
    ss_multi0 = 0; ss1_rise0 = 0; mseq0 = '0; ss_seen0 = '0; rsp_last0 = '0;
  endtask

  task automatic clr1();
    tog1 = 0; gap1 = 0; gmin1 = 9999; gmax1 = 0; rsp_n1 = 0; ss_low1 = 0;
  endtask

  task automatic issue0(input logic [7:0] d, input logic [1:0] s, input logic k,
                        input logic pol, input logic pha, input logic lsb, input logic [15:0] dv);
    int t;
    @(negedge clk);
    if0.io_cmd_data = d;  if0.io_cmd_ss = s;  if0.io_cmd_keepSs = k;
    if0.io_cfg_cpol = pol; if0.io_cfg_cpha = pha; if0.io_cfg_lsbFirst = lsb;
    if0.io_cfg_divider = dv;
    if0.io_cmd_valid = 1'b1;
    t = 0;
    while (!if0.io_cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("dut0_accept_timeout", 64'(t >= 200), 0);
    @(negedge clk);
    if0.io_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp0(output logic [7:0] d);
    int t;
    t = 0;
    while (!if0.io_rsp_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("dut0_rsp_timeout", 64'(t >= 2000), 0);
    d = if0.io_rsp_data;
  endtask

  task automatic wait_idle0();
    int t;
    t = 0;
    while (!(if0.io_cmd_ready && !if0.io_busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("dut0_idle_timeout", 64'(t >= 500), 0);
  endtask

  task automatic issue1(input logic [31:0] d, input logic s, input logic pol,
                        input logic pha, input logic lsb, input logic [15:0] dv);
    int t;
    @(negedge clk);
    if1.io_cmd_data = d;  if1.io_cmd_ss = s;  if1.io_cmd_keepSs = 1'b0;
    if1.io_cfg_cpol = pol; if1.io_cfg_cpha = pha; if1.io_cfg_lsbFirst = lsb;
    if1.io_cfg_divider = dv;
    if1.io_cmd_valid = 1'b1;
    t = 0;
    while (!if1.io_cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("dut1_accept_timeout", 64'(t >= 200), 0);
    @(negedge clk);
    if1.io_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp1(output logic [31:0] d);
    int t;
    t = 0;
    while (!if1.io_rsp_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("dut1_rsp_timeout", 64'(t >= 2000), 0);
    d = if1.io_rsp_data;
    t = 0;
    while (!(if1.io_cmd_ready && !if1.io_busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("dut1_idle_timeout", 64'(t >= 500), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  r8;
    logic [31:0] r32;
    int          n;

    rst_n = 1'b1;
    if0.io_cmd_valid = 1'b0; if0.io_cmd_data = '0; if0.io_cmd_ss = '0; if0.io_cmd_keepSs = 1'b0;
    if0.io_cfg_cpol = 1'b0; if0.io_cfg_cpha = 1'b0; if0.io_cfg_lsbFirst = 1'b0; if0.io_cfg_divider = '0;
    if1.io_cmd_valid = 1'b0; if1.io_cmd_data = '0; if1.io_cmd_ss = '0; if1.io_cmd_keepSs = 1'b0;
    if1.io_cfg_cpol = 1'b0; if1.io_cfg_cpha = 1'b0; if1.io_cfg_lsbFirst = 1'b0; if1.io_cfg_divider = '0;
    clr0();
    clr1();
    #2 rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ss",        if0.io_spi_ss,    4'hF);
    chk("rst_sclk",      if0.io_spi_sclk,  0);
    chk("rst_mosi",      if0.io_spi_mosi,  0);
    chk("rst_rsp_valid", if0.io_rsp_valid, 0);
    chk("rst_rsp_data",  if0.io_rsp_data,  0);
    chk("rst_busy",      if0.io_busy,      0);
    chk("rst_ready",     if0.io_cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_release",  if0.io_cmd_ready, 1);
    chk("ready1_after_release", if1.io_cmd_ready, 1);

    // Mode 0, MSB first, divider 1, ss 2, loopback; extra valid while busy must be ignored
    clr0();
    loop0 = 1'b1;
    issue0(8'hA5, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    #1;
    chk("m0_ss_after_accept",   if0.io_spi_ss,   4'hB);
    chk("m0_busy_after_accept", if0.io_busy,     1);
    chk("m0_sclk_idle",         if0.io_spi_sclk, 0);
    if0.io_cmd_data = 8'h00; if0.io_cmd_ss = 2'd3; if0.io_cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    if0.io_cmd_valid = 1'b0;
    wait_rsp0(r8);
    chk("m0_rsp_data", r8, 8'hA5);
    wait_idle0();
    #1;
    chk("m0_toggles",  tog0,      16);
    chk("m0_gap_min",  gmin0,     2);
    chk("m0_gap_max",  gmax0,     2);
    chk("m0_mosi_seq", mseq0,     8'hA5);
    chk("m0_ss_seen",  ss_seen0,  4'b0100);
    chk("m0_rsp_cnt",  rsp_n0,    1);
    chk("m0_ss_multi", ss_multi0, 0);

    // Mode 3, LSB first, miso tied high
    clr0();
    loop0 = 1'b0; tie0 = 1'b1;
    issue0(8'h3C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2);
    #1;
    chk("m3_sclk_idle_high", if0.io_spi_sclk, 1);
    chk("m3_ss_after_accept", if0.io_spi_ss, 4'hE);
    wait_rsp0(r8);
    chk("m3_rsp_data", r8, 8'hFF);
    wait_idle0();
    #1;
    chk("m3_mosi_seq", mseq0, 8'h3C);
    chk("m3_toggles",  tog0,  16);
    chk("m3_gap_min",  gmin0, 3);
    chk("m3_gap_max",  gmax0, 3);
    chk("m3_sclk_end", if0.io_spi_sclk, 1);

    // Back-to-back words on ss 1 with keepSs, then release
    clr0();
    loop0 = 1'b1;
    issue0(8'h5A, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    wait_rsp0(r8);
    chk("keep_rsp1", r8, 8'h5A);
    issue0(8'hC3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    #1;
    chk("keep_ss_held", if0.io_spi_ss, 4'hD);
    wait_rsp0(r8);
    chk("keep_rsp2", r8, 8'hC3);
    #1;
    chk("keep_ss_released", if0.io_spi_ss, 4'hF);
    n = 0;
    while (!if0.io_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("keep_deselect_len", n, 2);
    #1;
    chk("keep_ss1_rises", ss1_rise0, 1);
    chk("keep_rsp_cnt",   rsp_n0,    2);

    // Held select on ss 0, then a command for ss 3
    clr0();
    issue0(8'h0F, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    wait_rsp0(r8);
    chk("sw_rsp1", r8, 8'h0F);
    chk("sw_ss0_held", if0.io_spi_ss, 4'hE);
    issue0(8'h81, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    #1;
    chk("sw_ss_released", if0.io_spi_ss, 4'hF);
    n = 0;
    while (if0.io_spi_ss[3] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sw_deselect_len", n, 3);
    chk("sw_ss3_low", if0.io_spi_ss, 4'h7);
    wait_rsp0(r8);
    chk("sw_rsp2", r8, 8'h81);
    wait_idle0();
    #1;
    chk("sw_ss_multi", ss_multi0, 0);
    chk("sw_rsp_cnt",  rsp_n0,    2);

    // Reset during the 5th bit (mode 2 so sclk has to fall back to 0)
    clr0();
    issue0(8'hFF, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
    n = 0;
    while (tog0 < 9 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_reach_bit5", 64'(n >= 500), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ss",    if0.io_spi_ss,    4'hF);
    chk("abort_sclk",  if0.io_spi_sclk,  0);
    chk("abort_busy",  if0.io_busy,      0);
    chk("abort_ready", if0.io_cmd_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_ready_after", if0.io_cmd_ready, 1);
    chk("abort_rsp_cnt",     rsp_n0,           0);
    chk("abort_rsp_data",    if0.io_rsp_data,  0);

    // 32-bit word, divider 0, single slave
    clr1();
    loop1 = 1'b1;
    issue1(32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    wait_rsp1(r32);
    #1;
    chk("w32_rsp_data", r32,   32'hDEADBEEF);
    chk("w32_toggles",  tog1,  64);
    chk("w32_gap_min",  gmin1, 1);
    chk("w32_gap_max",  gmax1, 1);
    chk("w32_ss_used",  64'(ss_low1 > 0), 1);
    chk("w32_rsp_cnt",  rsp_n1, 1);

    // Out-of-range select: clocked with ss high, response still produced
    clr1();
    issue1(32'h12345678, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1);
    wait_rsp1(r32);
    #1;
    chk("oor_rsp_data", r32,    32'h12345678);
    chk("oor_ss_low",   ss_low1, 0);
    chk("oor_toggles",  tog1,   64);
    chk("oor_rsp_cnt",  rsp_n1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
